// File: rtl/byte_to_word_pkg.sv
// Shared types and helpers for the 8-bit to 16-bit memory dump engine.
// Records are {source byte address, byte value}.
package byte_to_word_pkg;

    localparam int AW8  = 8;
    localparam int DW8  = 8;
    localparam int AW16 = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic logic [AW8+DW8-1:0] pack_rec(input logic [AW8-1:0] addr8,
                                                    input logic [DW8-1:0] data8);
        return {addr8, data8};
    endfunction

endpackage

// File: rtl/byte_to_word_packer.sv
// Scans an inclusive range of the 8-bit memory and writes one {addr, byte}
// record per byte to consecutive 16-bit memory locations starting at a base.
module byte_to_word_packer
    import byte_to_word_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW8-1:0]    first_addr,
    input  logic [AW8-1:0]    last_addr,
    input  logic [AW16-1:0]   base_addr,
    input  logic              skip_zero,
    output logic              mem8_rd_en,
    output logic [AW8-1:0]    mem8_addr,
    input  logic [DW8-1:0]    mem8_rdata,
    output logic              mem16_we,
    output logic [AW16-1:0]   mem16_addr,
    output logic [AW8+DW8-1:0] mem16_wdata,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [AW8:0]      words_written,
    output state_t            dbg_state
);

    // Handshake: start is only looked at in IDLE; busy covers RD..DONE and
    // done pulses for exactly one cycle, after which start is accepted again.

    state_t          r_state;
    state_t          w_next_state;
    logic [AW8-1:0]  r_cur;
    logic [AW8-1:0]  r_last;
    logic            r_skip;
    logic [AW16-1:0] r_wptr;
    logic [AW8:0]    r_count;
    logic [DW8-1:0]  r_byte;
    logic            r_range_err;
    logic [AW8:0]    r_words;

    logic            w_range_bad;
    logic            w_write;
    logic            w_at_last;

    assign w_range_bad = (first_addr > last_addr);
    assign w_write     = (r_state == WR) && !(r_skip && (r_byte == '0));
    assign w_at_last   = (r_cur == r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_range_bad ? DONE : RD;
                end
            end
            RD:      w_next_state = WAIT;
            WAIT:    w_next_state = WR;
            WR:      w_next_state = w_at_last ? DONE : RD;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur       <= '0;
            r_last      <= '0;
            r_skip      <= 1'b0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_byte      <= '0;
            r_range_err <= 1'b0;
            r_words     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count     <= '0;
                        r_range_err <= w_range_bad;
                        if (w_range_bad) begin
                            r_words <= '0;
                        end else begin
                            r_last <= last_addr;
                            r_skip <= skip_zero;
                            r_cur  <= first_addr;
                            r_wptr <= base_addr;
                        end
                    end
                end
                WAIT: begin
                    r_byte <= mem8_rdata;
                end
                WR: begin
                    if (w_write) begin
                        r_wptr  <= r_wptr + 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    // Compare before increment so a last address of all-ones never wraps.
                    if (w_at_last) begin
                        r_words <= r_count + {{AW8{1'b0}}, w_write};
                    end else begin
                        r_cur <= r_cur + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem8_rd_en    = (r_state == RD);
        mem8_addr     = mem8_rd_en ? r_cur : '0;
        mem16_we      = w_write;
        mem16_addr    = w_write ? r_wptr : '0;
        mem16_wdata   = w_write ? pack_rec(r_cur, r_byte) : '0;
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        range_err     = r_range_err;
        words_written = r_words;
        dbg_state     = r_state;
    end

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Directed bench for byte_to_word_packer: a table of whole jobs plus
// hand-written sequences for reset, start-while-busy and start-with-reset.
module tb_byte_to_word_packer;
    import byte_to_word_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  first_addr = '0;
    logic [7:0]  last_addr = '0;
    logic [15:0] base_addr = '0;
    logic        skip_zero = 1'b0;
    logic        mem8_rd_en;
    logic [7:0]  mem8_addr;
    logic [7:0]  mem8_rdata = '0;
    logic        mem16_we;
    logic [15:0] mem16_addr;
    logic [15:0] mem16_wdata;
    logic        busy;
    logic        done;
    logic        range_err;
    logic [8:0]  words_written;
    state_t      dbg_state;

    byte_to_word_packer dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .base_addr(base_addr), .skip_zero(skip_zero),
        .mem8_rd_en(mem8_rd_en), .mem8_addr(mem8_addr), .mem8_rdata(mem8_rdata),
        .mem16_we(mem16_we), .mem16_addr(mem16_addr), .mem16_wdata(mem16_wdata),
        .busy(busy), .done(done), .range_err(range_err),
        .words_written(words_written), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter / 8-bit memory ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem8 [256];
    always @(posedge clk) begin
        if (mem8_rd_en) mem8_rdata <= mem8[mem8_addr];
    end

    // ---------------- monitor ----------------
    int job_id = 0;
    int t0 = 0;
    int last_id = 0;
    logic [31:0] act_q[$];
    int done_cnt, done_cyc, busy_cnt, rd_cnt, viol;
    logic [8:0] done_words;
    logic done_rerr;

    always @(negedge clk) begin
        if (job_id != last_id) begin
            last_id = job_id;
            act_q.delete();
            done_cnt = 0; done_cyc = -1; busy_cnt = 0; rd_cnt = 0; viol = 0;
            done_words = '0; done_rerr = 1'b0;
        end
        if (mem16_we) act_q.push_back({mem16_addr, mem16_wdata});
        if (done) begin
            done_cnt++;
            done_cyc = cyc - t0;
            done_words = words_written;
            done_rerr = range_err;
        end
        if (busy) busy_cnt++;
        if (mem8_rd_en) rd_cnt++;
        if (!mem8_rd_en && mem8_addr != 8'h00) viol++;
        if (!mem16_we && (mem16_addr != 16'h0000 || mem16_wdata != 16'h0000)) viol++;
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_miss = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_records(input string tag);
        check({tag, "_nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s_rec%0d", tag, i), act_q[i], exp_q[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic kick(input logic [7:0] f, input logic [7:0] l,
                        input logic [15:0] b, input logic s);
        @(posedge clk); #1;
        first_addr = f; last_addr = l; base_addr = b; skip_zero = s;
        start = 1'b1;
        t0 = cyc;
        job_id++;
        @(posedge clk); #1;
        start = 1'b0;
        // Running job must not depend on live inputs after acceptance.
        first_addr = 8'($urandom); last_addr = 8'($urandom);
        base_addr = 16'($urandom); skip_zero = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]  first;
        logic [7:0]  last;
        logic [15:0] base;
        logic        skip;
        logic [1:0]  n_wr;
        logic [15:0] a0, d0, a1, d1, a2, d2;
        logic [7:0]  done_cyc;
        logic [8:0]  words;
        logic        rerr;
        logic [8:0]  n_rd;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(logic [7:0] f, logic [7:0] l, logic [15:0] b, logic s,
                                logic [1:0] n, logic [15:0] a0, logic [15:0] d0,
                                logic [15:0] a1, logic [15:0] d1, logic [15:0] a2,
                                logic [15:0] d2, logic [7:0] dc, logic [8:0] w,
                                logic re, logic [8:0] nrd);
        vec_t v;
        v.first = f; v.last = l; v.base = b; v.skip = s; v.n_wr = n;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
        v.done_cyc = dc; v.words = w; v.rerr = re; v.n_rd = nrd;
        return v;
    endfunction

    initial begin
        vec_t v;
        vecs[0] = mk(8'h10, 8'h12, 16'h0100, 1'b0, 2'd3, 16'h0100, 16'h10AA,
                     16'h0101, 16'h1100, 16'h0102, 16'h125C, 8'd10, 9'd3, 1'b0, 9'd3);
        vecs[1] = mk(8'h10, 8'h12, 16'h0100, 1'b1, 2'd2, 16'h0100, 16'h10AA,
                     16'h0101, 16'h125C, 16'h0, 16'h0, 8'd10, 9'd2, 1'b0, 9'd3);
        vecs[2] = mk(8'hFF, 8'hFF, 16'hFFFF, 1'b0, 2'd1, 16'hFFFF, 16'hFF01,
                     16'h0, 16'h0, 16'h0, 16'h0, 8'd4, 9'd1, 1'b0, 9'd1);
        vecs[3] = mk(8'hFE, 8'hFF, 16'hFFFF, 1'b0, 2'd2, 16'hFFFF, 16'hFE7E,
                     16'h0000, 16'hFF01, 16'h0, 16'h0, 8'd7, 9'd2, 1'b0, 9'd2);
        vecs[4] = mk(8'h20, 8'h1F, 16'h0500, 1'b0, 2'd0, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 8'd1, 9'd0, 1'b1, 9'd0);
        vecs[5] = mk(8'h10, 8'h10, 16'h0200, 1'b0, 2'd1, 16'h0200, 16'h10AA,
                     16'h0, 16'h0, 16'h0, 16'h0, 8'd4, 9'd1, 1'b0, 9'd1);
        vecs[6] = mk(8'h11, 8'h11, 16'h0200, 1'b1, 2'd0, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 8'd4, 9'd0, 1'b0, 9'd1);

        for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom_range(1, 255));
        mem8[8'h10] = 8'hAA; mem8[8'h11] = 8'h00; mem8[8'h12] = 8'h5C;
        mem8[8'hFE] = 8'h7E; mem8[8'hFF] = 8'h01;
        mem8[8'h00] = 8'h3C; mem8[8'h01] = 8'h00;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", {30'd0, mem8_rd_en, mem16_we}, 32'd0);
        check("rst_addrs", {mem8_addr, mem16_addr, 8'd0}, 32'd0);
        check("rst_wdata", 32'(mem16_wdata), 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_rerr", 32'(range_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // ---- table-driven jobs ----
        for (int i = 0; i < 7; i++) begin
            string tag;
            v = vecs[i];
            tag = $sformatf("v%0d", i);
            exp_q.delete();
            if (v.n_wr > 0) exp_q.push_back({v.a0, v.d0});
            if (v.n_wr > 1) exp_q.push_back({v.a1, v.d1});
            if (v.n_wr > 2) exp_q.push_back({v.a2, v.d2});
            kick(v.first, v.last, v.base, v.skip);
            wait_done(tag);
            check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
            check({tag, "_done_cyc"}, 32'(done_cyc), 32'(v.done_cyc));
            check_records(tag);
            check({tag, "_words"}, 32'(done_words), 32'(v.words));
            check({tag, "_rerr"}, 32'(done_rerr), 32'(v.rerr));
            check({tag, "_words_held"}, 32'(words_written), 32'(v.words));
            check({tag, "_rerr_held"}, 32'(range_err), 32'(v.rerr));
            check({tag, "_reads"}, 32'(rd_cnt), 32'(v.n_rd));
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(v.done_cyc));
            check({tag, "_idle_zero"}, 32'(viol), 32'd0);
        end

        // ---- start while busy: pulses at cycles 2 and 5 are ignored ----
        exp_q.delete();
        exp_q.push_back({16'h0100, 16'h10AA});
        exp_q.push_back({16'h0101, 16'h1100});
        exp_q.push_back({16'h0102, 16'h125C});
        kick(8'h10, 8'h12, 16'h0100, 1'b0);
        @(posedge clk); #1;
        first_addr = 8'h00; last_addr = 8'h0F; base_addr = 16'h0700;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        check("busy_start_done_cnt", 32'(done_cnt), 32'd1);
        check("busy_start_done_cyc", 32'(done_cyc), 32'd10);
        check_records("busy_start");
        check("busy_start_words", 32'(words_written), 32'd3);

        // ---- reset mid-job at cycle 7 ----
        exp_q.delete();
        exp_q.push_back({16'h0300, 16'h003C});
        exp_q.push_back({16'h0301, 16'h0100});
        kick(8'h00, 8'h0F, 16'h0300, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_at_cycle", 32'(cyc - t0), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        check("midrst_strobes", {30'd0, mem8_rd_en, mem16_we}, 32'd0);
        check("midrst_words_rerr", {22'd0, words_written, range_err}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check_records("midrst");
        check("midrst_no_done", 32'(done_cnt), 32'd0);

        // ---- start in the same cycle as rst is ignored ----
        @(posedge clk); #1;
        rst = 1'b1;
        first_addr = 8'h10; last_addr = 8'h12; base_addr = 16'h0100;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_state", 32'(dbg_state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x0, want 0x1");
        $fatal(1, "timeout");
    end

endmodule
